// File: rtl/dmem_defs.sv
// Shared encodings and lane helpers for the wait-state data memory.
package dmem_defs;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // size 2'b11 behaves as a word because only size[1] is tested for words
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      if (size[1])      return 2'b00;
      else if (size[0]) return {off[1], 1'b0};
      else              return off;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size[1])      return |off;
      else if (size[0]) return off[0];
      else              return 1'b0;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] aoff);
      if (size[1])      return 4'hF;
      else if (size[0]) return aoff[1] ? 4'hC : 4'h3;
      else              return 4'b0001 << aoff;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// lane select plus sign/zero extension for loads.
module dmem_lane_align
   import dmem_defs::*;
(
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rext,
   output logic        misalign
);

   logic [1:0]  aoff;
   logic [31:0] shifted;

   assign aoff     = align_off(size, off);
   assign be       = lane_be(size, aoff);
   assign misalign = is_misaligned(size, off);

   // Replicating the data across lanes lets the byte enables pick the target lane
   always_comb begin
      wword = wdata;
      if (!size[1]) begin
         if (size[0]) wword = {2{wdata[15:0]}};
         else         wword = {4{wdata[7:0]}};
      end
   end

   assign shifted = rword >> {aoff, 3'b000};

   always_comb begin
      rext = shifted;
      if (!size[1]) begin
         if (size[0]) rext = {{16{sign & shifted[15]}}, shifted[15:0]};
         else         rext = {{24{sign & shifted[7]}},  shifted[7:0]};
      end
   end

endmodule

// File: rtl/wait_state_data_memory.sv
// Data memory with LATENCY wait states behind a req/ack handshake.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses with err instead of aligning them.
module wait_state_data_memory
   import dmem_defs::*;
#(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [31:0] memFile [0:DEPTH-1];

   state_t      state;
   logic [3:0]  cnt;
   logic        l_we;
   logic [1:0]  l_size;
   logic        l_sign;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;

   logic [ADDR_W-1:0] idx;
   logic [31:0]       rword;
   logic [3:0]        be;
   logic [31:0]       wword;
   logic [31:0]       rext;
   logic              misalign;
   logic              trap;
   logic              commit;
   logic              mem_we;

   assign idx   = l_addr[ADDR_W+1:2];
   assign rword = memFile[idx];

   dmem_lane_align u_align (
      .size     (l_size),
      .sign     (l_sign),
      .off      (l_addr[1:0]),
      .wdata    (l_wdata),
      .rword    (rword),
      .be       (be),
      .wword    (wword),
      .rext     (rext),
      .misalign (misalign)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   assign trap = misalign;
   logic unused_bits;
   assign unused_bits = ^l_addr[31:ADDR_W+2];
`else
   assign trap = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{l_addr[31:ADDR_W+2], misalign};
`endif

   // Every access passes through WAIT so ack lands LATENCY edges after capture, even for LATENCY==1
   assign commit = (state == S_WAIT) && (cnt == 4'd0);
   assign mem_we = commit && l_we && !trap && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         ack     <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'd0;
         l_we    <= 1'b0;
         l_size  <= SZ_BYTE;
         l_sign  <= 1'b0;
         l_addr  <= 32'd0;
         l_wdata <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  l_we    <= we;
                  l_size  <= size;
                  l_sign  <= sign;
                  l_addr  <= addr;
                  l_wdata <= wdata;
                  cnt     <= LAT_M1;
                  busy    <= 1'b1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
                  ack   <= 1'b1;
                  err   <= trap;
                  rdata <= (l_we || trap) ? 32'd0 : rext;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               ack   <= 1'b0;
               busy  <= 1'b0;
               err   <= 1'b0;
               rdata <= 32'd0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Store commits on the same edge that raises ack, so a following load sees the new data
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) memFile[idx][8*b +: 8] <= wword[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Directed bench for wait_state_data_memory (LATENCY=3, DEPTH=1024).
module tb_wait_state_data_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          bcnt;
   int          acks;

   wait_state_data_memory dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .we    (we),
      .size  (size),
      .sign  (sign),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ack   (ack),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait (bounded) for ack, report data/err/latency/busy cycles, then
   // verify the port returns to idle on the following cycle.
   task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r, output logic e,
                         output int l, output int bc);
      int k;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = d;
      k = 0; bc = 0; l = -1; r = 32'hx; e = 1'bx;
      while (k < 20 && l < 0) begin
         @(posedge clk); #1;
         k++;
         req = 1'b0;
         if (busy) bc++;
         if (ack) begin
            l = k - 1; r = rdata; e = err;
         end
      end
      if (l < 0) begin
         errors++;
         $display("FAIL ack_timeout: observed no ack expected ack within 20 cycles");
      end
      @(posedge clk); #1;
      check("idle_ack",   {31'd0, ack},  32'd0);
      check("idle_busy",  {31'd0, busy}, 32'd0);
      check("idle_rdata", rdata,         32'd0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      dut.memFile[2] = 32'hCAFE_BABE;
      dut.memFile[3] = 32'h1122_3344;
      dut.memFile[5] = 32'h8000_00F0;
      dut.memFile[8] = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack",   {31'd0, ack},  32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_err",   {31'd0, err},  32'd0);
      check("rst_rdata", rdata,         32'd0);
      @(negedge clk); reset = 1'b0;

      // lw 0x0C
      access(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0, rd, er, lat, bcnt);
      check("lw_data",    rd,          32'h1122_3344);
      check("lw_latency", 32'(lat),    32'd3);
      check("lw_busy",    32'(bcnt),   32'd4);
      check("lw_err",     {31'd0, er}, 32'd0);

      // sb 0xAB at 0x0D then lw 0x0C
      access(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB, rd, er, lat, bcnt);
      check("sb_latency", 32'(lat), 32'd3);
      check("sb_mem",     dut.memFile[3], 32'h1122_AB44);
      access(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0, rd, er, lat, bcnt);
      check("lw_after_sb", rd, 32'h1122_AB44);

      // sign/zero extension
      access(1'b0, 2'b00, 1'b1, 32'h0000_0014, 32'd0, rd, er, lat, bcnt);
      check("lb",  rd, 32'hFFFF_FFF0);
      access(1'b0, 2'b00, 1'b0, 32'h0000_0014, 32'd0, rd, er, lat, bcnt);
      check("lbu", rd, 32'h0000_00F0);
      access(1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'd0, rd, er, lat, bcnt);
      check("lh",  rd, 32'hFFFF_8000);
      access(1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'd0, rd, er, lat, bcnt);
      check("lhu", rd, 32'h0000_8000);
      access(1'b0, 2'b00, 1'b1, 32'h0000_0017, 32'd0, rd, er, lat, bcnt);
      check("lb_b3", rd, 32'hFFFF_FF80);

      // sh to upper half leaves lower half alone
      access(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h1234_BEEF, rd, er, lat, bcnt);
      check("sh_mem", dut.memFile[5], 32'hBEEF_00F0);

      // address wrap above DEPTH words
      access(1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'd0, rd, er, lat, bcnt);
      check("wrap", rd, 32'hCAFE_BABE);

      // size 11 behaves as word
      access(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'd0, rd, er, lat, bcnt);
      check("size11", rd, 32'h1122_AB44);

      // misaligned word load
      access(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'd0, rd, er, lat, bcnt);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("mis_err",   {31'd0, er}, 32'd1);
      check("mis_rdata", rd,          32'd0);
      access(1'b1, 2'b10, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, rd, er, lat, bcnt);
      check("mis_st_err", {31'd0, er}, 32'd1);
      check("mis_st_mem", dut.memFile[8], 32'h1234_5678);
`else
      check("mis_err",   {31'd0, er}, 32'd0);
      check("mis_rdata", rd,          32'h1122_AB44);
`endif

      // reset one cycle after capturing a word store
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0;
      addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      req = 1'b0;
      check("rst_mid_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("rst_mid_ack",   {31'd0, ack},  32'd0);
      check("rst_mid_busy0", {31'd0, busy}, 32'd0);
      check("rst_mid_err",   {31'd0, err},  32'd0);
      check("rst_mid_rdata", rdata,         32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      acks = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      check("rst_mid_noack", 32'(acks),      32'd0);
      check("rst_mid_mem",   dut.memFile[8], 32'h1234_5678);
      check("rst_mid_idle",  {31'd0, busy},  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
